alu_issue_capture: RTL and testbench
====================================

Name: alu_issue_capture

Overview:
- Sequential wrapper stage around the 16-bit ripple-carry ALU datapath.
- Upstream side: accepts one operation request (operands, S, M, cin) per valid/ready handshake and registers it onto the ALU inputs.
- Holds the ALU inputs stable for a programmable settle time so the ripple carry propagates, then captures F and cout into an output register with Zero/Negative flags.
- Keeps a carry flag so multi-word add/subtract can chain carry between successive operations.

Parameters:
- WIDTH, 16, datapath width; must match the ALU instance.
- SETTLE_CYCLES, 2, number of clock edges ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_s  input  4  ALU function select.
- in_m  input  1  ALU mode (1 = logic, 0 = arithmetic).
- in_cin  input  1  explicit carry-in.
- in_use_carry  input  1  1 = use the stored carry flag as carry-in instead of in_cin.
- alu_a, alu_b  output  WIDTH  registered operands driven to the ALU.
- alu_s  output  4  registered select.
- alu_m  output  1  registered mode.
- alu_cin  output  1  registered carry-in.
- alu_f  input  WIDTH  ALU result.
- alu_cout  input  1  ALU carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_f  output  WIDTH  captured result.
- out_cout  output  1  captured carry-out.
- out_zero  output  1  1 when out_f == 0.
- out_neg  output  1  equals out_f[WIDTH-1].
- carry_flag  output  1  stored chain carry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; settle counter = 0.
  - All alu_*, out_*, out_valid and carry_flag = 0.
  - in_ready = 1 once in IDLE.
  - Any in-flight operation is aborted; out_valid drops immediately.
- States: IDLE, SETTLE, DONE.
- in_ready (combinational) = (state == IDLE) | (state == DONE & out_ready).
- Accept edge (in_valid & in_ready):
  - Register in_a, in_b, in_s and in_m onto the alu_* outputs.
  - alu_cin = in_use_carry ? carry_flag : in_cin, where carry_flag is the registered value before this edge.
  - Load counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - Counter != 0: decrement.
  - Counter == 0: capture alu_f → out_f and alu_cout → out_cout/carry_flag; compute out_zero and out_neg from alu_f; set out_valid = 1; go to DONE.
- Latency: out_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- alu_* outputs hold their value from the accept edge until the next accept edge; they are never changed during SETTLE.
- DONE:
  - out_valid = 1; out_f, out_cout, out_zero, out_neg are stable until out_ready.
  - out_ready & !in_valid: out_valid -> 0, go to IDLE.
  - out_ready & in_valid: result drains and the new request is accepted on the same edge; go to SETTLE.
  - A chained request accepted on this edge sees carry_flag = the result being drained.
  - Steady-state throughput: one op per SETTLE_CYCLES+1 cycles.
- in_valid during SETTLE is ignored: in_ready = 0; the requester must hold it.
- in_valid high in the same cycle reset is released: not accepted before the first rising edge with rst_n high.
- carry_flag changes only on capture edges or reset. A logic-mode (M=1) capture still updates it with alu_cout.
- Arithmetic: none internal. Flags derive only from captured alu_f; no overflow flag.

Test Plan:
- Bench drives alu_f/alu_cout from a stub computing {cout,F} = A+B+cin, combinational.
- Reset then single op: A=16'h1234, B=16'h0F0F, cin=0, SETTLE_CYCLES=2 → out_valid exactly 2 edges after accept; out_f=16'h2143, cout=0, zero=0, neg=0.
- Carry chain (32-bit add as two ops): low A=16'hFFFF, B=16'h0001, cin=0 → out_f=16'h0000, cout=1, zero=1, carry_flag=1; then high op with in_use_carry=1, A=16'h0000, B=16'h0000 → alu_cin=1, out_f=16'h0001, carry_flag=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_f stable, in_ready=0 throughout; raising out_ready with in_valid=1 drains and accepts on the same edge.
- Back-to-back: 4 requests with out_ready=1 constant → one result every 3 cycles (SETTLE_CYCLES=2) in issue order; alu_* never change during SETTLE.
- Mid-op reset: assert rst_n=0 while in SETTLE → out_valid, carry_flag and alu_* = 0 asynchronously; after release, in_ready=1 and the next op completes normally.
- Negative result: A=16'h8000, B=16'h0000, cin=0 → out_neg=1, out_zero=0, out_cout=0.

Source files
------------

// File: rtl/alu_issue_capture.sv
// Issue/capture stage wrapped around a combinational ripple-carry ALU: registers one
// request onto the ALU inputs, waits a programmable settle time, then captures the result.
module alu_issue_capture #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_s,
    input  logic             in_m,
    input  logic             in_cin,
    input  logic             in_use_carry,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             carry_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The counter reaches zero on the edge before capture, giving SETTLE_CYCLES edges total.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       accept_s;
    logic       capture_s;
    logic       drain_s;

    // Handshake decode: a held result may drain on the same edge a new request is taken.
    always_comb begin
        in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
        accept_s  = in_valid & in_ready;
        capture_s = (state_r == SETTLE) & (cnt_r == 4'd0);
        drain_s   = (state_r == DONE) & out_ready;
    end

    // State and settle-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETTLE;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_s = SETTLE;
                    cnt_s   = CNT_LOAD;
                end else if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // ALU input registers: loaded only on accept so the ripple path sees stable operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= {WIDTH{1'b0}};
            alu_b   <= {WIDTH{1'b0}};
            alu_s   <= 4'd0;
            alu_m   <= 1'b0;
            alu_cin <= 1'b0;
        end else if (accept_s) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            alu_s   <= in_s;
            alu_m   <= in_m;
            alu_cin <= in_use_carry ? carry_flag : in_cin;
        end
    end

    // Result capture; carry_flag follows cout in both modes so word chains stay simple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_f      <= {WIDTH{1'b0}};
            out_cout   <= 1'b0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            carry_flag <= 1'b0;
        end else if (capture_s) begin
            out_f      <= alu_f;
            out_cout   <= alu_cout;
            out_zero   <= (alu_f == {WIDTH{1'b0}});
            out_neg    <= alu_f[WIDTH-1];
            carry_flag <= alu_cout;
        end
    end

    // Result-valid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (capture_s) begin
            out_valid <= 1'b1;
        end else if (drain_s) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_capture.sv
// Self-checking bench for alu_issue_capture: an adder stub stands in for the ALU and a
// transaction-level model predicts handshake, result and carry behaviour every cycle.
module tb_alu_issue_capture;

    localparam int W  = 16;
    localparam int SC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_m, in_cin, in_use_carry;
    logic [W-1:0] in_a, in_b;
    logic [3:0]   in_s;
    logic [W-1:0] alu_a, alu_b, alu_f;
    logic [3:0]   alu_s;
    logic         alu_m, alu_cin, alu_cout;
    logic         out_valid, out_ready, out_cout, out_zero, out_neg, carry_flag;
    logic [W-1:0] out_f;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int n;
    int done_cycles[$];

    // Model: an op in flight finishes SETTLE edges after acceptance, then is held until drained.
    bit           m_inflight, m_hold, m_acc, m_cout, m_carry, m_m, m_cin;
    int           m_left;
    logic [W-1:0] m_a, m_b, m_f;
    logic [3:0]   m_s;

    always #5 clk = ~clk;

    // ALU stand-in: plain addition with carry.
    assign {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};

    alu_issue_capture #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_cin(in_cin),
        .in_use_carry(in_use_carry), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_m(alu_m), .alu_cin(alu_cin), .alu_f(alu_f), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_cout(out_cout),
        .out_zero(out_zero), .out_neg(out_neg), .carry_flag(carry_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit model_ready();
        return !m_inflight && (!m_hold || out_ready);
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_hold = 0; m_acc = 0; m_left = 0;
        m_cout = 0; m_carry = 0; m_f = '0;
        m_a = '0; m_b = '0; m_s = '0; m_m = 0; m_cin = 0;
    endtask

    // Advance the model across one rising edge using the inputs that were stable before it.
    task automatic model_edge();
        bit rdy, drain;
        logic [W:0] sum;
        rdy   = model_ready();
        m_acc = rst_n && in_valid && rdy;
        drain = m_hold && out_ready;
        if (rst_n) begin
            if (m_inflight && m_left == 1) begin
                sum = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                {m_cout, m_f} = sum;
                m_carry    = m_cout;
                m_hold     = 1;
                m_inflight = 0;
                done_cycles.push_back(cyc);
            end else if (m_inflight) begin
                m_left--;
            end else if (drain) begin
                m_hold = 0;
            end
            if (m_acc) begin
                m_cin = in_use_carry ? m_carry : in_cin;
                m_a = in_a; m_b = in_b; m_s = in_s; m_m = in_m;
                m_inflight = 1;
                m_left     = SC;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, model_ready());
            chk("out_valid", out_valid, m_hold);
            chk("carry_flag", carry_flag, m_carry);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_s", alu_s, m_s);
            chk("alu_m", alu_m, m_m);
            chk("alu_cin", alu_cin, m_cin);
            if (m_hold) begin
                chk("out_f", out_f, m_f);
                chk("out_cout", out_cout, m_cout);
                chk("out_zero", out_zero, (m_f == '0));
                chk("out_neg", out_neg, m_f[W-1]);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic use_c, input bit keep);
        int k;
        in_a = a; in_b = b; in_s = 4'h9; in_m = 1'b0; in_cin = cin; in_use_carry = use_c;
        in_valid = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!m_acc && k < 50);
        chk("accept_timeout", m_acc, 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (!m_hold && edges < 50) begin
            cycle();
            edges++;
        end
        chk("result_timeout", m_hold, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0;
        in_cin = 1'b0; in_use_carry = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_out_f", out_f, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Single op and latency.
        issue(16'h1234, 16'h0F0F, 1'b0, 1'b0, 0);
        wait_result(n);
        chk("latency", n, SC);
        chk("single_f", out_f, 16'h2143);
        chk("single_cout", out_cout, 0);
        chk("single_zero", out_zero, 0);
        chk("single_neg", out_neg, 0);
        out_ready = 1'b1;
        cycle();
        chk("single_drained", out_valid, 0);

        // Two-word add: carry from the low word feeds the high word.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        wait_result(n);
        chk("lo_f", out_f, 16'h0000);
        chk("lo_cout", out_cout, 1);
        chk("lo_zero", out_zero, 1);
        chk("lo_carry", carry_flag, 1);
        issue(16'h0000, 16'h0000, 1'b0, 1'b1, 0);
        chk("hi_alu_cin", alu_cin, 1);
        wait_result(n);
        chk("hi_f", out_f, 16'h0001);
        chk("hi_carry", carry_flag, 0);
        cycle();

        // Backpressure: the result holds and new work waits until out_ready.
        out_ready = 1'b0;
        issue(16'h0100, 16'h0023, 1'b0, 1'b0, 0);
        wait_result(n);
        in_a = 16'h0FF0; in_b = 16'h000F; in_cin = 1'b0; in_use_carry = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_f", out_f, 16'h0123);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_same_edge_alu_a", alu_a, 16'h0FF0);
        chk("bp_same_edge_valid", out_valid, 0);
        in_valid = 1'b0;
        wait_result(n);
        chk("bp_next_f", out_f, 16'h0FFF);
        cycle();

        // Back-to-back: one result per SC+1 cycles in order.
        done_cycles.delete();
        for (int i = 0; i < 4; i++) issue(16'(16'h1000 * (i + 1)), 16'(i), 1'b0, 1'b0, 1);
        in_valid = 1'b0;
        wait_result(n);
        chk("b2b_last_f", out_f, 16'h4003);
        chk("b2b_count", done_cycles.size(), 4);
        for (int i = 1; i < done_cycles.size(); i++)
            chk("b2b_spacing", done_cycles[i] - done_cycles[i-1], SC + 1);
        cycle();

        // Mid-op reset aborts the operation asynchronously.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        wait_result(n);
        cycle();
        issue(16'h5555, 16'h1111, 1'b1, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_carry", carry_flag, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_cin", alu_cin, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        model_reset();
        cycle();
        rst_n = 1'b1;
        issue(16'h0202, 16'h0101, 1'b0, 1'b1, 0);
        wait_result(n);
        chk("post_rst_f", out_f, 16'h0303);
        cycle();

        // Negative result.
        issue(16'h8000, 16'h0000, 1'b0, 1'b0, 0);
        wait_result(n);
        chk("neg_neg", out_neg, 1);
        chk("neg_zero", out_zero, 0);
        chk("neg_cout", out_cout, 0);
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid     = 1'($urandom_range(0, 1));
            out_ready    = 1'($urandom_range(0, 3) != 0);
            in_a         = 16'($urandom);
            in_b         = ($urandom_range(0, 3) == 0) ? 16'(-int'(in_a)) : 16'($urandom);
            in_s         = 4'($urandom);
            in_m         = 1'($urandom);
            in_cin       = 1'($urandom);
            in_use_carry = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
